// File: rtl/core_fetch_unit.sv
// Instruction-fetch front end: PC, DEPTH-entry prefetch queue and a pipelined
// request/grant read port with redirect flush and pause drain.
module core_fetch_unit #(
  parameter int ADDR_W  = 15,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_isBooted,
  input  logic                     i_redirect,
  input  logic [ADDR_W-1:0]        i_redirectAddr,
  output logic                     o_memReq,
  output logic [ADDR_W-1:0]        o_memAddr,
  input  logic                     i_memGnt,
  input  logic                     i_memValid,
  input  logic [INSTR_W-1:0]       i_memData,
  output logic [INSTR_W-1:0]       o_instr,
  output logic [ADDR_W-1:0]        o_instrPc2,
  output logic                     o_instrValid,
  input  logic                     i_instrTake,
  input  logic                     i_pauseReq,
  output logic                     o_nowPaused,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int OCC_W  = LVL_W + 1;
  // Back-to-back redirects can leave several queues' worth of stale reads in flight.
  localparam int DISC_W = LVL_W + 2;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [LVL_W-1:0]   outstanding_q, outstanding_d;
  logic [DISC_W-1:0]  discard_q, discard_d;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc2_mem   [DEPTH];
  logic [ADDR_W-1:0]  tag_mem   [DEPTH];

  logic [OCC_W-1:0]   occupancy;
  logic               grant, kept, push, pop;

  // NOTE: every signal assigned in always_comb gets a value on entry, so no path can infer a latch.
  always_comb begin
    occupancy = {1'b0, level_q} + {1'b0, outstanding_q};
    o_memReq  = ~i_rst & i_isBooted & ~i_pauseReq & ~i_redirect
              & (occupancy < OCC_W'(DEPTH));
    grant     = o_memReq & i_memGnt;
    kept      = i_memValid & (discard_q == '0);
    push      = kept & ~i_redirect;
    pop       = i_instrTake & (level_q != '0) & ~i_redirect;
  end

  always_comb begin
    pc_d          = pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    tag_rd_d      = tag_rd_q;
    tag_wr_d      = tag_wr_q;
    level_d       = level_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (i_redirect) begin
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      tag_rd_d      = '0;
      tag_wr_d      = '0;
      level_d       = '0;
      outstanding_d = '0;
      // A response in this cycle retires one read, whether it was stale or live.
      discard_d     = discard_q + DISC_W'(outstanding_q) - DISC_W'(i_memValid);
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        tag_rd_d = tag_rd_q + PTR_W'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (grant)
        tag_wr_d = tag_wr_q + PTR_W'(1);
      level_d       = level_q + LVL_W'(push) - LVL_W'(pop);
      outstanding_d = outstanding_q + LVL_W'(grant) - LVL_W'(kept);
      if (i_memValid && discard_q != '0)
        discard_d = discard_q - DISC_W'(1);
    end

    if (!i_isBooted)
      pc_d = RESET_ADDR;
    else if (i_redirect)
      pc_d = i_redirectAddr;
    else if (grant)
      pc_d = pc_q + ADDR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q          <= RESET_ADDR;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      tag_rd_q      <= '0;
      tag_wr_q      <= '0;
      level_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      tag_rd_q      <= tag_rd_d;
      tag_wr_q      <= tag_wr_d;
      level_q       <= level_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // NOTE: storage arrays carry no reset; the level count decides which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= i_memData;
      pc2_mem[wr_ptr_q]   <= tag_mem[tag_rd_q];
    end
    if (grant)
      tag_mem[tag_wr_q] <= pc_q + ADDR_W'(1);
  end

  assign o_memAddr    = pc_q;
  assign o_level      = level_q;
  assign o_instrValid = (level_q != '0);
  assign o_instr      = o_instrValid ? instr_mem[rd_ptr_q] : '0;
  assign o_instrPc2   = o_instrValid ? pc2_mem[rd_ptr_q] : '0;
  assign o_nowPaused  = ~i_rst & i_pauseReq & (outstanding_q == '0) & (discard_q == '0);

endmodule

// File: tb/tb_core_fetch_unit.sv
// Randomised scoreboard bench for core_fetch_unit: a memory responder, an
// expected-address stream rebuilt on every redirect, and directed corner cases.
module tb_core_fetch_unit;

  localparam int ADDR_W  = 15;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;
  localparam logic [ADDR_W-1:0] RESET_ADDR = '0;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  i_isBooted, i_redirect, i_memGnt, i_memValid, i_instrTake, i_pauseReq;
  logic [ADDR_W-1:0]     i_redirectAddr;
  logic [INSTR_W-1:0]    i_memData;
  logic                  o_memReq, o_instrValid, o_nowPaused;
  logic [ADDR_W-1:0]     o_memAddr, o_instrPc2;
  logic [INSTR_W-1:0]    o_instr;
  logic [$clog2(DEPTH):0] o_level;

  core_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
    .i_clk(clk), .i_rst(rst), .i_isBooted(i_isBooted),
    .i_redirect(i_redirect), .i_redirectAddr(i_redirectAddr),
    .o_memReq(o_memReq), .o_memAddr(o_memAddr), .i_memGnt(i_memGnt),
    .i_memValid(i_memValid), .i_memData(i_memData),
    .o_instr(o_instr), .o_instrPc2(o_instrPc2), .o_instrValid(o_instrValid),
    .i_instrTake(i_instrTake), .i_pauseReq(i_pauseReq), .o_nowPaused(o_nowPaused),
    .o_level(o_level)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int grant_cnt = 0;
  int pop_cnt   = 0;

  // Knobs read by step(); percentages are per-cycle probabilities.
  int  gnt_pct = 0, resp_pct = 0, take_pct = 0;
  bit  booted_k = 1'b0, pause_k = 1'b0, redir_req = 1'b0;
  logic [ADDR_W-1:0] redir_addr = '0;

  logic [ADDR_W-1:0] mem_pend [$];   // granted, not yet answered, oldest first
  logic [ADDR_W-1:0] exp_q    [$];   // addresses the consumer must see, in order
  logic [ADDR_W-1:0] exp_tail = RESET_ADDR;
  bit seen;
  int g0, p0;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    int v;
    v = (int'(a) * 40503 + 4660) & 'hFFFF;
    return INSTR_W'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs at the falling edge, return 3 time units later.
  task automatic step();
    @(negedge clk);
    i_isBooted  = booted_k;
    i_pauseReq  = pause_k;
    i_instrTake = ($urandom_range(99) < take_pct);
    i_memGnt    = ($urandom_range(99) < gnt_pct);
    if (mem_pend.size() > 0 && $urandom_range(99) < resp_pct) begin
      i_memValid = 1'b1;
      i_memData  = mem_word(mem_pend.pop_front());
    end else begin
      i_memValid = 1'b0;
      i_memData  = INSTR_W'($urandom);
    end
    i_redirect = redir_req;
    if (redir_req) begin
      i_redirectAddr = redir_addr;
      exp_q.delete();
      exp_tail  = booted_k ? redir_addr : RESET_ADDR;
      redir_req = 1'b0;
    end else begin
      i_redirectAddr = ADDR_W'($urandom);
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + ADDR_W'(1);
    end
    #3;
  endtask

  task automatic drain();
    bit done;
    done     = 1'b0;
    pause_k  = 1'b1;
    take_pct = 100;
    resp_pct = 100;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      done = o_nowPaused && !o_instrValid;
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  // Monitor: memory-side grant capture plus consumer-side scoreboard.
  always @(negedge clk) begin
    logic [ADDR_W-1:0] a, nx;
    #2;
    if (!rst) begin
      check("level_bound", 32'(o_level <= DEPTH), 32'd1);
      check("valid_vs_level", 32'(o_instrValid), 32'(o_level != 0));
      if (i_redirect || i_pauseReq || !i_isBooted)
        check("req_gated", 32'(o_memReq), 32'd0);
      check("now_paused", 32'(o_nowPaused),
            32'(i_pauseReq && mem_pend.size() == 0 && !i_memValid));
      if (o_memReq && i_memGnt) begin
        mem_pend.push_back(o_memAddr);
        grant_cnt++;
      end
      if (o_instrValid && i_instrTake && !i_redirect) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          check("exp_stream_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          a  = exp_q.pop_front();
          nx = a + ADDR_W'(1);
          check("instr", 32'(o_instr), 32'(mem_word(a)));
          check("instr_pc2", 32'(o_instrPc2), 32'(nx));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_isBooted = 1'b0; i_redirect = 1'b0; i_redirectAddr = '0; i_memGnt = 1'b0;
    i_memValid = 1'b0; i_memData = '0; i_instrTake = 1'b0; i_pauseReq = 1'b0;

    // Reset state, with inputs that would otherwise request and report paused.
    booted_k = 1'b1; pause_k = 1'b1; gnt_pct = 100; take_pct = 100;
    repeat (2) step();
    check("rst_memReq", 32'(o_memReq), 32'd0);
    check("rst_memAddr", 32'(o_memAddr), 32'(RESET_ADDR));
    check("rst_valid", 32'(o_instrValid), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_paused", 32'(o_nowPaused), 32'd0);
    check("rst_instr", 32'(o_instr), 32'd0);
    check("rst_pc2", 32'(o_instrPc2), 32'd0);

    // Not booted: no requests, PC pinned even across a redirect.
    booted_k = 1'b0; pause_k = 1'b0;
    step();
    rst = 1'b0;
    resp_pct = 100;
    repeat (3) step();
    check("noboot_req", 32'(o_memReq), 32'd0);
    redir_req = 1'b1; redir_addr = 15'h0055;
    repeat (2) step();
    check("noboot_addr", 32'(o_memAddr), 32'(RESET_ADDR));

    // Boot and stream at full rate.
    booted_k = 1'b1;
    repeat (20) step();
    p0 = pop_cnt;
    repeat (10) step();
    check("stream_rate", 32'(pop_cnt - p0), 32'd10);

    // Full stall: exactly DEPTH grants from empty, then a single refill.
    drain();
    pause_k = 1'b0; take_pct = 0; gnt_pct = 100; resp_pct = 100;
    g0 = grant_cnt;
    repeat (12) step();
    check("stall_grants", 32'(grant_cnt - g0), 32'd4);
    check("stall_level", 32'(o_level), 32'd4);
    check("stall_req", 32'(o_memReq), 32'd0);
    resp_pct = 0; take_pct = 100;
    step();
    take_pct = 0;
    repeat (2) step();
    check("refill_grants", 32'(grant_cnt - g0), 32'd5);
    check("refill_req", 32'(o_memReq), 32'd0);
    check("refill_level", 32'(o_level), 32'd3);
    take_pct = 100; resp_pct = 100;
    step();
    take_pct = 0; resp_pct = 0;
    step();
    check("pushpop_level", 32'(o_level), 32'd3);

    // Redirect with two reads outstanding and one queued instruction.
    drain();
    pause_k = 1'b0; take_pct = 0; gnt_pct = 100; resp_pct = 0;
    repeat (3) step();
    gnt_pct = 0; resp_pct = 100;
    step();
    resp_pct = 0;
    step();
    check("redir_pre_level", 32'(o_level), 32'd1);
    redir_req = 1'b1; redir_addr = 15'h0100; gnt_pct = 100;
    step();
    step();
    check("redir_flush_valid", 32'(o_instrValid), 32'd0);
    check("redir_addr", 32'(o_memAddr), 32'h0100);
    resp_pct = 100;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = o_instrValid;
    end
    check("redir_valid_seen", 32'(seen), 32'd1);
    check("redir_first_pc2", 32'(o_instrPc2), 32'h0101);
    check("redir_first_instr", 32'(o_instr), 32'(mem_word(15'h0100)));

    // Pause with three reads in flight, responses two cycles apart.
    drain();
    pause_k = 1'b0; take_pct = 0; gnt_pct = 100; resp_pct = 0;
    repeat (3) step();
    gnt_pct = 0; pause_k = 1'b1;
    for (int i = 0; i < 5; i++) begin
      resp_pct = (i % 2 == 0) ? 100 : 0;
      step();
      check("pause_wait", 32'(o_nowPaused), 32'd0);
    end
    resp_pct = 0;
    step();
    check("pause_done", 32'(o_nowPaused), 32'd1);
    check("pause_level", 32'(o_level), 32'd3);
    pause_k = 1'b0; take_pct = 100; gnt_pct = 100; resp_pct = 100;
    repeat (20) step();

    // PC wrap from all-ones to zero.
    redir_req = 1'b1; redir_addr = 15'h7FFF; take_pct = 0;
    step();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = o_instrValid;
    end
    check("wrap_valid_seen", 32'(seen), 32'd1);
    check("wrap_pc2", 32'(o_instrPc2), 32'd0);
    check("wrap_instr", 32'(o_instr), 32'(mem_word(15'h7FFF)));
    take_pct = 100;
    step();
    take_pct = 0;
    step();
    check("wrap_next_pc2", 32'(o_instrPc2), 32'd1);
    check("wrap_next_instr", 32'(o_instr), 32'(mem_word(15'h0000)));

    // Random traffic with redirects and pause toggling.
    gnt_pct = 70; resp_pct = 60; take_pct = 65;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) begin
        redir_req  = 1'b1;
        redir_addr = ($urandom_range(3) == 0) ? ADDR_W'(32'h7FFD + $urandom_range(2))
                                              : ADDR_W'($urandom);
      end
      if ($urandom_range(99) < 3)
        pause_k = !pause_k;
      step();
    end
    pause_k = 1'b0; take_pct = 100; resp_pct = 100; gnt_pct = 100;
    repeat (20) step();

    // Asynchronous reset with a full queue.
    take_pct = 0;
    repeat (12) step();
    check("prereset_level", 32'(o_level), 32'd4);
    rst = 1'b1;
    mem_pend.delete();
    exp_q.delete();
    exp_tail = RESET_ADDR;
    #1;
    check("arst_memReq", 32'(o_memReq), 32'd0);
    check("arst_memAddr", 32'(o_memAddr), 32'(RESET_ADDR));
    check("arst_valid", 32'(o_instrValid), 32'd0);
    check("arst_level", 32'(o_level), 32'd0);
    check("arst_paused", 32'(o_nowPaused), 32'd0);
    check("arst_instr", 32'(o_instr), 32'd0);
    check("arst_pc2", 32'(o_instrPc2), 32'd0);
    gnt_pct = 0;
    repeat (2) step();
    rst = 1'b0;
    step();
    check("postrst_addr", 32'(o_memAddr), 32'(RESET_ADDR));
    gnt_pct = 100; take_pct = 100;
    repeat (15) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
